// File: rtl/ucsbece152a_counter_pkg.sv
// rtl/ucsbece152a_counter_pkg.sv - shared constants for the up/down counter
package ucsbece152a_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/ucsbece152a_counter.sv
// rtl/ucsbece152a_counter.sv - modulo 2**WIDTH up/down counter with enable
module ucsbece152a_counter
  import ucsbece152a_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Wrap-around falls out of plain WIDTH-bit arithmetic.
  always_comb begin
    count_d = count_q;
    if (enable_i) begin
      if (dir_i == DIR_DOWN) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_ucsbece152a_counter.sv
// tb/tb_ucsbece152a_counter.sv - directed self-checking bench for ucsbece152a_counter
module tb_ucsbece152a_counter;

  logic       clk;
  logic       rst;
  logic       en3, dir3;
  logic       en1, dir1;
  logic       en8, dir8;
  logic [2:0] count3;
  logic [0:0] count1;
  logic [7:0] count8;

  int checks = 0;
  int errors = 0;

  ucsbece152a_counter #(.WIDTH(3)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .enable_i (en3),
    .dir_i    (dir3),
    .count_o  (count3)
  );

  ucsbece152a_counter #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .enable_i (en1),
    .dir_i    (dir1),
    .count_o  (count1)
  );

  ucsbece152a_counter #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .enable_i (en8),
    .dir_i    (dir8),
    .count_o  (count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit past it for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    en3  = 1'b1; dir3 = 1'b0;
    en1  = 1'b0; dir1 = 1'b0;
    en8  = 1'b0; dir8 = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b0;
    #1;
    check("reset_async", 32'(count3), 32'd0);
    step();
    check("reset_held_enabled", 32'(count3), 32'd0);

    // Release away from the edge, then 16 enabled up-edges.
    #3 rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("up_%0d", i), 32'(count3), 32'((i + 1) % 8));
    end

    // Mid-count reset at 5, asserted between edges.
    for (int i = 0; i < 5; i++) step();
    check("pre_reset_5", 32'(count3), 32'd5);
    #2 rst = 1'b0;
    #1;
    check("midreset_async", 32'(count3), 32'd0);
    step();
    check("midreset_held_a", 32'(count3), 32'd0);
    dir3 = 1'b1;
    step();
    check("midreset_held_b", 32'(count3), 32'd0);
    dir3 = 1'b0;
    #3 rst = 1'b1;
    step();
    check("after_release", 32'(count3), 32'd1);

    // Hold at 3 with dir toggling and mid-cycle enable glitches.
    step(); step();
    check("pre_hold_3", 32'(count3), 32'd3);
    en3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dir3 = ~dir3;
      #2 en3 = 1'b1;
      #1 en3 = 1'b0;
      step();
      check($sformatf("hold_%0d", i), 32'(count3), 32'd3);
    end
    en3 = 1'b1; dir3 = 1'b0;
    step();
    check("reenable_up", 32'(count3), 32'd4);

    // Down wrap from a fresh zero.
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    check("down_start", 32'(count3), 32'd0);
    dir3 = 1'b1;
    step(); check("down_7", 32'(count3), 32'd7);
    step(); check("down_6", 32'(count3), 32'd6);
    step(); check("down_5", 32'(count3), 32'd5);

    // Direction switch before the edge: 6 -> 5.
    dir3 = 1'b0;
    step();
    check("dirchg_at6_a", 32'(count3), 32'd6);
    dir3 = 1'b1;
    step();
    check("dirchg_before_edge", 32'(count3), 32'd5);

    // Direction switch after the edge: 6 -> 7, then down to 6.
    dir3 = 1'b0;
    step();
    check("dirchg_at6_b", 32'(count3), 32'd6);
    step();
    check("dirchg_after_edge", 32'(count3), 32'd7);
    dir3 = 1'b1;
    step();
    check("dirchg_then_down", 32'(count3), 32'd6);

    // Parameter sweep on the WIDTH=1 and WIDTH=8 instances.
    en3 = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("sweep_reset_w1", 32'(count1), 32'd0);
    check("sweep_reset_w8", 32'(count8), 32'd0);
    rst = 1'b1;
    en1 = 1'b1; dir1 = 1'b0;
    en8 = 1'b1; dir8 = 1'b1;
    step();
    check("w1_up_1", 32'(count1), 32'd1);
    check("w8_down_255", 32'(count8), 32'd255);
    step();
    check("w1_up_0", 32'(count1), 32'd0);
    check("w8_down_254", 32'(count8), 32'd254);
    check("w3_idle", 32'(count3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucsbece152a_counter.md
UCSBECE152A_COUNTER -- requirements
Module: ucsbece152a_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the counter bit width; legal range 1 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset that is asynchronous and active-low (0 = reset asserted).
REQ-004 The block SHALL have port enable_i, input, 1 bit, count enable; 1 = count, 0 = hold.
REQ-005 The block SHALL have port dir_i, input, 1 bit, count direction; 0 = up, 1 = down.
REQ-006 The block SHALL have port count_o, output, WIDTH bits, current count value, unsigned.

Function
REQ-007 The counter SHALL be a single WIDTH-bit register driven directly onto count_o, with no combinational logic between the register and the output.
REQ-008 The counter SHALL be updated at each rising clk edge while rst is deasserted:
- enable_i=1, dir_i=0: count+1.
- enable_i=1, dir_i=1: count-1.
- enable_i=0: hold, regardless of dir_i.
REQ-009 Arithmetic SHALL be modulo 2**WIDTH:
- Up from 2**WIDTH-1 wraps to 0.
- Down from 0 wraps to 2**WIDTH-1.
- There is no saturation, carry-out or terminal-count flag.
REQ-010 Latency SHALL be one cycle: a change on enable_i or dir_i affects only the next rising-edge update after the inputs are sampled.
REQ-011 enable_i and dir_i SHALL be sampled only at the rising clk edge; glitches between edges have no effect.
REQ-012 The count following 16 consecutive enabled up-edges from 0 with WIDTH=3 SHALL be 0, and intermediate values SHALL be i mod 8.

Reset
REQ-013 Asserting rst (0) SHALL force count_o to 0 immediately, without waiting for a clk edge.
REQ-014 While rst is asserted, count_o SHALL remain 0 regardless of clk, enable_i and dir_i.
REQ-015 Counting SHALL resume from 0 at the first rising clk edge at which rst is deasserted (1).
REQ-016 rst asserted mid-count SHALL discard the current value; there is no retained state.

Structure
REQ-017 A shared package SHALL hold the default width constant (3) and the direction encodings (UP=0, DOWN=1); the module imports them.
REQ-018 The block SHALL be implemented as a single module with no sub-modules: one sequential process for the register and one combinational next-count process.

Verification
REQ-019 A bench running with WIDTH=3 SHALL cover the following scenarios:
- Up count: rst=0 for one cycle, then rst=1, enable_i=1, dir_i=0 for 16 edges -> count_o sequence 0,1,...,7,0,1,...,7.
- Mid-count reset: at count 5, drive rst=0 between edges -> count_o=0 before the next clk edge; it stays 0 while held; after release the next edge gives 1.
- Hold: at count 3, enable_i=0 with dir_i toggling for 4 edges -> count_o stays 3; re-enabling up gives 4 on the next edge.
- Down wrap: from count 0, enable_i=1, dir_i=1 for 3 edges -> 7, 6, 5.
- Direction change: at count 6 counting up, switch dir_i=1 -> next edge 7 (already sampled up) only if the switch comes after the edge; a switch before the edge gives 5. Check both timings.
- Parameter sweep: WIDTH=1 up-count alternates 0,1,0; WIDTH=8 down from 0 gives 255.
